// File: rtl/dtc_stream_driver_if.sv
// Handshake bundle for dtc_stream_driver: 1-bit feature stream in, classified result out.
// The slave view belongs to the driver; the master view belongs to the feature source / result sink.
interface dtc_stream_driver_if #(
    parameter int N_FEAT = 8
);
    logic              s_valid;
    logic              s_ready;
    logic              s_bit;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_label;
    logic [N_FEAT-1:0] m_vec;

    modport slave (
        input  s_valid,
        input  s_bit,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_label,
        output m_vec
    );

    modport master (
        output s_valid,
        output s_bit,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_label,
        input  m_vec
    );
endinterface

// File: rtl/dtc_stream_driver.sv
// Bit-serial deserializer and result capture around a decision-tree classifier.
// Optional result counters n_total/n_pos are built when DTC_DRV_STATS_EN is defined.
module dtc_stream_driver #(
    parameter int N_FEAT = 8,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    dtc_stream_driver_if.slave bus,
    output logic [N_FEAT-1:0] feat_o,
    input  logic              cls_i,
    output logic              err
`ifdef DTC_DRV_STATS_EN
    ,
    output logic [15:0]       n_total,
    output logic [15:0]       n_pos
`endif
);

    localparam int                CNT_W    = $clog2(N_FEAT);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_FEAT - 1);
    localparam logic [3:0]        LAT_V    = 4'(LAT);

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        DROP  = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       wcnt;
    logic             ready;
    logic             accept;
    logic             at_last;
    logic             frame_short;
    logic             frame_long;
    logic             capture;

    assign ready       = (state == SHIFT) || (state == DROP);
    assign accept      = bus.s_valid && ready;
    assign at_last     = (cnt == LAST_IDX);
    assign frame_short = (state == SHIFT) && accept && bus.s_last && !at_last;
    assign frame_long  = (state == SHIFT) && accept && !bus.s_last && at_last;
    assign capture     = (state == EVAL) && (wcnt == LAT_V);

    assign bus.s_ready = ready;
    assign bus.m_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SHIFT: begin
                if (accept && at_last) begin
                    state_nxt = bus.s_last ? EVAL : DROP;
                end
            end
            DROP: begin
                if (accept && bus.s_last) begin
                    state_nxt = SHIFT;
                end
            end
            EVAL: begin
                if (capture) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = SHIFT;
        endcase
    end

    // Deserializer: beat k lands in feat_o[k]; any s_last or the final slot restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            feat_o <= '0;
        end else if ((state == SHIFT) && accept) begin
            feat_o[cnt] <= bus.s_bit;
            if (bus.s_last || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if ((state == EVAL) && !capture) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_label <= 1'b0;
            bus.m_vec   <= '0;
        end else if (capture) begin
            bus.m_label <= cls_i;
            bus.m_vec   <= feat_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_short || frame_long) begin
            err <= 1'b1;
        end
    end

`ifdef DTC_DRV_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic handshake;
    assign handshake = (state == HOLD) && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_total <= '0;
            n_pos   <= '0;
        end else if (handshake) begin
            n_total <= sat_inc(n_total);
            if (bus.m_label) begin
                n_pos <= sat_inc(n_pos);
            end
        end
    end
`endif

endmodule
